monolith_bricks_seq: RTL
========================

MONOLITH_BRICKS_SEQ -- requirements
Module: monolith_bricks_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 31: element width; modulus p = 2^WORD_WIDTH - 1 (Mersenne).
REQ-002 SHALL have parameter STATE_SIZE, default 16: elements per state, legal range 2..64.
REQ-003 SHALL have parameter NUM_MUL, default 4: forward-mode squarer/adder lanes, legal range 1..STATE_SIZE-1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_valid  input  1  state_in and in_mode are valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a state.
REQ-008 SHALL have port in_mode  input  1  0 = forward bricks, 1 = inverse bricks.
REQ-009 SHALL have port state_in  input  STATE_SIZE x WORD_WIDTH  input state, element 0 first.
REQ-010 SHALL have port out_valid  output  1  state_out holds a finished result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts state_out.
REQ-012 SHALL have port state_out  output  STATE_SIZE x WORD_WIDTH  result state, registered.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FWD, INV, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept a state on a rising edge with in_valid && in_ready: register state_in, register in_mode, clear the batch/element counter, go to FWD (mode 0) or INV (mode 1).
REQ-016 SHALL treat input value 2^W-1 as 0; every state_out element SHALL be canonical in [0, p-1], element 0 included.
REQ-017 Forward SHALL compute out[0] = x[0], out[i] = (x[i] + x[i-1]^2) mod p for i >= 1, using only the registered input values.
REQ-018 FWD SHALL process NUM_MUL consecutive indices per cycle, starting at i = 1, for B = ceil((STATE_SIZE-1)/NUM_MUL) cycles; lanes beyond index STATE_SIZE-1 in the last batch SHALL write nothing.
REQ-019 Inverse SHALL compute x[0] = y[0], x[i] = (y[i] - x[i-1]^2) mod p, one index per cycle (i = 1..STATE_SIZE-1), using the already-recovered x[i-1].
REQ-020 Squaring SHALL produce the full 2W-bit product and reduce it by Mersenne folding (low W bits + high bits, one conditional subtract of p); add/subtract SHALL use a W+1-bit intermediate with one conditional correction.
REQ-021 Latency: with acceptance on edge k, out_valid SHALL rise after edge k+B (forward) or k+STATE_SIZE-1 (inverse); defaults give 4 and 15.
REQ-022 On transition to DONE, state_out SHALL hold the full result and remain stable while out_valid && !out_ready.
REQ-023 On a rising edge with out_valid && out_ready, the FSM SHALL go to IDLE; the new in_ready is visible in the next cycle (no same-cycle re-accept).
REQ-024 in_valid, in_mode and state_in SHALL be ignored outside IDLE.
REQ-025 state_out SHALL retain its last value in IDLE until the next result overwrites it at DONE entry.

Reset
REQ-026 While reset = 0 (asynchronous assertion), FSM SHALL be IDLE, counters 0, all state_out elements 0, out_valid = 0, busy = 0, in_ready = 1.
REQ-027 Reset asserted during FWD, INV or DONE SHALL abort the operation with no partial result visible; deassertion SHALL be synchronous to clk.

Verification
REQ-028 Forward, all x[i] = 1, out_ready = 1 -> out[0] = 1, out[1..15] = 2; out_valid 4 cycles after acceptance.
REQ-029 Forward, all x[i] = 0x7FFFFFFE (-1 mod p) -> out[0] = 0x7FFFFFFE, out[1..15] = 0.
REQ-030 Forward, all x[i] = 0x7FFFFFFF -> all out = 0 (non-canonical zero handled).
REQ-031 Inverse of a random forward result -> original input recovered exactly; out_valid 15 cycles after acceptance.
REQ-032 out_ready held low 5 cycles in DONE -> state_out stable, in_ready = 0, second in_valid ignored; NUM_MUL = 1 and NUM_MUL = 15 builds give identical results with B = 15 and 1.
REQ-033 reset pulsed low at cycle 7 of INV -> outputs 0 immediately, in_ready = 1; next accepted state completes correctly.

Source files
------------

// File: rtl/monolith_bricks_seq_if.sv
// monolith_bricks_seq_if: input/output state handshake bundle for the bricks sequencer
interface monolith_bricks_seq_if #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
);
  logic in_valid;
  logic in_ready;
  logic in_mode;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in;
  logic out_valid;
  logic out_ready;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out;
  logic busy;
  modport master (
    output in_valid, in_mode, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );
  modport slave (
    input  in_valid, in_mode, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/monolith_bricks_seq.sv
// monolith_bricks_seq: forward/inverse Monolith bricks layer over a Mersenne field
module monolith_bricks_seq #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16,
  parameter int NUM_MUL    = 4
) (
  input logic clk,
  input logic reset,
  monolith_bricks_seq_if.slave bus
);
  localparam int W  = WORD_WIDTH;
  localparam int S  = STATE_SIZE;
  localparam int IW = $clog2(S);
  localparam int B  = (S - 1 + NUM_MUL - 1) / NUM_MUL;
  localparam logic [W-1:0] P = {W{1'b1}};
  typedef enum logic [1:0] {IDLE, FWD, INV, DONE} state_t;
  typedef logic [S-1:0][W-1:0] vec_t;
  function automatic logic [W-1:0] fold(input logic [W:0] s);
    return (s >= {1'b0, P}) ? W'(s - {1'b0, P}) : s[W-1:0];
  endfunction
  function automatic logic [W-1:0] sq_mod(input logic [W-1:0] a);
    logic [2*W-1:0] m;
    m = (2*W)'(a) * (2*W)'(a);
    return fold({1'b0, m[W-1:0]} + {1'b0, m[2*W-1:W]});
  endfunction
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    return fold({1'b0, a} + {1'b0, b});
  endfunction
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[W] ? W'(d + {1'b0, P}) : d[W-1:0];
  endfunction
  state_t state_q;
  logic [IW-1:0] cnt_q, cnt_d;
  vec_t x_q, r_q, r_d, out_q, xin_c;
  logic in_ready_q, out_valid_q, busy_q, last;
  logic [NUM_MUL-1:0][IW-1:0] lane_i;
  logic [NUM_MUL-1:0] lane_v;
  logic [NUM_MUL-1:0][W-1:0] lane_r;
  logic [W-1:0] inv_r;
  // All-ones is the non-canonical encoding of zero; fold it once at capture
  for (genvar g = 0; g < S; g++) begin : g_canon
    assign xin_c[g] = (bus.state_in[g] == P) ? '0 : bus.state_in[g];
  end
  for (genvar g = 0; g < NUM_MUL; g++) begin : g_lane
    logic [31:0] k;
    assign k = 32'(cnt_q) * 32'(NUM_MUL) + 32'(g) + 32'd1;
    assign lane_v[g] = k < 32'(S);
    assign lane_i[g] = k[IW-1:0];
    assign lane_r[g] = add_mod(x_q[lane_i[g]], sq_mod(x_q[lane_i[g] - IW'(1)]));
  end
  assign cnt_d = cnt_q + IW'(1);
  // Inverse chains on the already-recovered previous element held in r_q
  assign inv_r = sub_mod(x_q[cnt_d], sq_mod(r_q[cnt_q]));
  assign last = (state_q == FWD) ? (cnt_d == IW'(B)) : (cnt_d == IW'(S - 1));
  always_comb begin
    r_d = r_q;
    if (state_q == FWD)
      for (int l = 0; l < NUM_MUL; l++)
        if (lane_v[l]) r_d[lane_i[l]] = lane_r[l];
    if (state_q == INV) r_d[cnt_d] = inv_r;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      r_q         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          x_q        <= xin_c;
          r_q        <= xin_c;
          cnt_q      <= '0;
          state_q    <= bus.in_mode ? INV : FWD;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        FWD, INV: begin
          r_q   <= r_d;
          cnt_q <= cnt_d;
          if (last) begin
            out_q       <= r_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.state_out = out_q;
endmodule
